// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
package seg7_pkg;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } mux_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_OFF    = 2'b11;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder, active-low, bit order gfedcba.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit common-anode display multiplexer with a blanking gap between digits.
//
// state  | meaning
// BLANK0 | both anodes off ahead of digit 0
// SHOW0  | digit 0 (right) lit from its captured value
// BLANK1 | both anodes off ahead of digit 1
// SHOW1  | digit 1 (left) lit from its captured value
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] LOAD_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_SHOW  = CW'(REFRESH_CYCLES - BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || REFRESH_CYCLES < BLANK_CYCLES + 1) begin : g_bad_params
    $error("seg7_mux_driver: need BLANK_CYCLES >= 1 and REFRESH_CYCLES > BLANK_CYCLES");
  end

  mux_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    dig0, dig1, hex_sel;
  logic [6:0]    seg_dec;
  logic          tc;

  assign tc = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt - CW'(1);
    case (state)
      BLANK0: if (tc) begin state_n = SHOW0;  cnt_n = LOAD_SHOW;  end
      SHOW0:  if (tc) begin state_n = BLANK1; cnt_n = LOAD_BLANK; end
      BLANK1: if (tc) begin state_n = SHOW1;  cnt_n = LOAD_SHOW;  end
      SHOW1:  if (tc) begin state_n = BLANK0; cnt_n = LOAD_BLANK; end
      default: begin
        state_n = BLANK0;
        cnt_n   = LOAD_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BLANK0;
      cnt   <= LOAD_BLANK;
      dig0  <= 4'h0;
      dig1  <= 4'h0;
      frame <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      frame <= (state == BLANK0) && (state_n == SHOW0);
      // Digits are latched only on entry to their slot so a slot never changes mid-display.
      if ((state == BLANK0) && (state_n == SHOW0)) dig0 <= d0;
      if ((state == BLANK1) && (state_n == SHOW1)) dig1 <= d1;
    end
  end

  assign hex_sel = (state == SHOW1) ? dig1 : dig0;

  hex_to_seg7 u_dec (
    .hex (hex_sel),
    .seg (seg_dec)
  );

  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    case (state)
      SHOW0: begin an = 2'b10; seg = seg_dec; end
      SHOW1: begin an = 2'b01; seg = seg_dec; end
      default: begin
        an  = AN_OFF;
        seg = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: directed vector table, hand sequences, and random run vs a slot-position model.
module tb_seg7_mux_driver;

  localparam int B = 2;
  localparam int R = 6;
  localparam int P = 2 * R;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] d0 = 4'h0;
  logic [3:0] d1 = 4'h0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // model state: position inside the 2R-cycle period and captured digit values
  int         pos = 0;
  logic [3:0] m_dig0 = 4'h0;
  logic [3:0] m_dig1 = 4'h0;

  logic [6:0] dec_tab [16];

  typedef struct {
    bit         rst_n;
    logic [3:0] v0;
    logic [3:0] v1;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    bit         e_frame;
  } vec_t;

  vec_t vecs [20];

  seg7_mux_driver #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .d0    (d0),
    .d1    (d1),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)", name, act, exp, pos, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("an_never_00", int'(an == 2'b00), 0);
      if (an == 2'b11) chk("blank_seg_when_off", seg, 7'h7f);
    end
  end

  task automatic tick(input bit rst_n, input logic [3:0] a, input logic [3:0] b);
    logic [1:0] x_an;
    logic [6:0] x_seg;
    bit         x_frame;
    reset = rst_n;
    d0    = a;
    d1    = b;
    @(posedge clk);
    if (!rst_n) begin
      pos    = 0;
      m_dig0 = 4'h0;
      m_dig1 = 4'h0;
    end else begin
      pos = (pos + 1) % P;
      if (pos == B)     m_dig0 = a;
      if (pos == R + B) m_dig1 = b;
    end
    #1;
    started = 1'b1;
    x_frame = 1'b0;
    if (pos < B) begin
      x_an = 2'b11; x_seg = 7'h7f;
    end else if (pos < R) begin
      x_an = 2'b10; x_seg = dec_tab[m_dig0]; x_frame = (pos == B) && rst_n;
    end else if (pos < R + B) begin
      x_an = 2'b11; x_seg = 7'h7f;
    end else begin
      x_an = 2'b01; x_seg = dec_tab[m_dig1];
    end
    chk("model_an", an, x_an);
    chk("model_seg", seg, x_seg);
    chk("model_frame", frame, x_frame);
  endtask

  function automatic vec_t mk(bit r, logic [3:0] a, logic [3:0] b,
                              logic [1:0] ea, logic [6:0] es, bit ef);
    vec_t v;
    v.rst_n = r; v.v0 = a; v.v1 = b; v.e_an = ea; v.e_seg = es; v.e_frame = ef;
    return v;
  endfunction

  initial begin
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // reset x3, then spec cycles 2..18; d0 drops to 0 from cycle 4 (mid-SHOW0)
    for (int i = 0; i < 3; i++) vecs[i] = mk(0, 4'h3, 4'h0, 2'b11, 7'h7f, 0);
    vecs[3]  = mk(1, 4'h1, 4'h8, 2'b11, 7'h7f, 0);
    vecs[4]  = mk(1, 4'h1, 4'h8, 2'b10, 7'h79, 1);
    for (int i = 5; i < 8; i++)   vecs[i] = mk(1, 4'h0, 4'h8, 2'b10, 7'h79, 0);
    for (int i = 8; i < 10; i++)  vecs[i] = mk(1, 4'h0, 4'h8, 2'b11, 7'h7f, 0);
    for (int i = 10; i < 14; i++) vecs[i] = mk(1, 4'h0, 4'h8, 2'b01, 7'h00, 0);
    for (int i = 14; i < 16; i++) vecs[i] = mk(1, 4'h0, 4'h8, 2'b11, 7'h7f, 0);
    vecs[16] = mk(1, 4'h0, 4'h8, 2'b10, 7'h40, 1);
    for (int i = 17; i < 20; i++) vecs[i] = mk(1, 4'h0, 4'h8, 2'b10, 7'h40, 0);

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].rst_n, vecs[i].v0, vecs[i].v1);
      chk($sformatf("vec%0d_an", i), an, vecs[i].e_an);
      chk($sformatf("vec%0d_seg", i), seg, vecs[i].e_seg);
      chk($sformatf("vec%0d_frame", i), frame, vecs[i].e_frame);
    end

    // decoder sweep: hold each d1 value for a full period
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < P; c++) begin
        tick(1, 4'($urandom_range(15)), 4'(v));
        if (pos == R + B) chk($sformatf("sweep_%0h", v), seg, dec_tab[v]);
      end

    // reset arriving in cycle 10 (SHOW1)
    tick(0, 4'h5, 4'h9);
    for (int c = 2; c <= 10; c++) tick(1, 4'h5, 4'h9);
    chk("pre_reset_an", an, 2'b01);
    tick(0, 4'h5, 4'h9);
    chk("midreset_an", an, 2'b11);
    chk("midreset_seg", seg, 7'h7f);
    tick(1, 4'h5, 4'h9);
    tick(1, 4'h5, 4'h9);
    chk("resume_an", an, 2'b10);
    chk("resume_seg", seg, dec_tab[5]);

    // random run with occasional resets
    for (int n = 0; n < 600; n++)
      tick($urandom_range(63) != 0, 4'($urandom_range(15)), 4'($urandom_range(15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
